// File: rtl/tpu_pkg.sv
// ============================================================================
// tpu_pkg : shared types and sizing helpers for the systolic-array TPU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

  localparam int C_WEIGHT_BW   = 8;
  localparam int C_NUM_PE_ROWS = 8;
  localparam int C_MATRIX_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } tpu_state_e;

  // Wide enough for a full column of products without overflow.
  function automatic int acc_bw(input int wbw, input int rows);
    return 2 * wbw + $clog2(rows);
  endfunction

  function automatic int weight_lsb(input int r, input int c, input int msize, input int wbw);
    return (r * msize + c) * wbw;
  endfunction

  function automatic int act_lsb(input int r, input int wbw);
    return r * wbw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_if.sv
// ============================================================================
// tpu_if : host-side bus of the TPU (SRAM, weight FIFO, job control, results)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface tpu_if
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int WEIGHT_BW   = C_WEIGHT_BW,
  parameter int NUM_PE_ROWS = C_NUM_PE_ROWS,
  parameter int MATRIX_SIZE = C_MATRIX_SIZE,
  parameter int ACC_BW      = acc_bw(WEIGHT_BW, NUM_PE_ROWS),
  parameter int DW          = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE
);

  logic                          start;
  logic                          end_;
  logic                          sram_write_enable;
  logic [ADDRESSSIZE-1:0]        sram_address;
  logic [WORDSIZE-1:0]           sram_data_in;
  logic [WORDSIZE-1:0]           sram_data_out;
  logic                          fifo_write_enable;
  logic                          fifo_read_enable;
  logic [DW-1:0]                 fifo_data_in;
  logic [DW-1:0]                 fifo_data_out;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          we_rl;
  logic                          valid_address;
  logic [MATRIX_SIZE*ACC_BW-1:0] psum_out;
  logic                          psum_valid;

  modport slave (
    input  start, sram_write_enable, sram_address, sram_data_in,
           fifo_write_enable, fifo_read_enable, fifo_data_in, we_rl, valid_address,
    output end_, sram_data_out, fifo_data_out, fifo_empty, fifo_full, psum_out, psum_valid
  );

  modport master (
    output start, sram_write_enable, sram_address, sram_data_in,
           fifo_write_enable, fifo_read_enable, fifo_data_in, we_rl, valid_address,
    input  end_, sram_data_out, fifo_data_out, fifo_empty, fifo_full, psum_out, psum_valid
  );

endinterface

`default_nettype wire

// File: rtl/tpu_pe.sv
// ============================================================================
// tpu_pe : weight-stationary PE; activation passes right, partial sum passes down
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tpu_pe #(
  parameter int WEIGHT_BW = 8,
  parameter int ACC_BW    = 19
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_we,
  input  logic [WEIGHT_BW-1:0] i_w,
  input  logic [WEIGHT_BW-1:0] i_a,
  input  logic [ACC_BW-1:0]    i_psum,
  output logic [WEIGHT_BW-1:0] o_a,
  output logic [ACC_BW-1:0]    o_psum
);

  logic signed [WEIGHT_BW-1:0]   r_w;
  logic signed [2*WEIGHT_BW-1:0] w_prod;
  logic signed [ACC_BW-1:0]      w_prod_ext;

  assign w_prod     = $signed(i_a) * r_w;
  assign w_prod_ext = ACC_BW'(w_prod);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_w    <= '0;
      o_a    <= '0;
      o_psum <= '0;
    end else begin
      if (i_we) begin
        r_w <= i_w;
      end
      o_a    <= i_a;
      o_psum <= i_psum + w_prod_ext;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tpu_top.sv
// ============================================================================
// tpu_top : SRAM + weight FIFO + skewed weight-stationary systolic array + FSM
// Build option: define TPU_RELU_EN to clamp negative column sums to zero.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tpu_top
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int WEIGHT_BW   = C_WEIGHT_BW,
  parameter int NUM_PE_ROWS = C_NUM_PE_ROWS,
  parameter int MATRIX_SIZE = C_MATRIX_SIZE,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic  clk,
  input  logic  rstn,
  tpu_if.slave  bus
);

  localparam int ACC_BW = acc_bw(WEIGHT_BW, NUM_PE_ROWS);
  localparam int DW     = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;
  localparam int LAT    = NUM_PE_ROWS + MATRIX_SIZE + 1;
  localparam int DEPTH  = 1 << ADDRESSSIZE;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- SRAM
  logic [WORDSIZE-1:0] r_sram_mem [DEPTH];
  logic [WORDSIZE-1:0] r_sram_dout;
  logic                w_sram_rd;

  assign w_sram_rd = bus.valid_address && !bus.sram_write_enable;

  always_ff @(posedge clk) begin
    if (bus.sram_write_enable) begin
      r_sram_mem[bus.sram_address] <= bus.sram_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_sram_dout <= '0;
    end else if (w_sram_rd) begin
      r_sram_dout <= r_sram_mem[bus.sram_address];
    end
  end

  // ---------------------------------------------------------- weight FIFO
  logic [DW-1:0]    r_fifo_mem [FIFO_DEPTH];
  logic [DW-1:0]    r_fifo_dout;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_fifo_empty;
  logic             r_fifo_full;
  logic             w_push;
  logic             w_pop;

  // Gate on the count, not the flags: the flags read 0 straight out of reset.
  assign w_push       = bus.fifo_write_enable && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_pop        = bus.fifo_read_enable && (r_count != '0);
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= bus.fifo_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fifo_dout  <= '0;
      r_fifo_empty <= 1'b0;
      r_fifo_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr    <= w_rd_ptr_inc;
        r_fifo_dout <= r_fifo_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      if (w_push || w_pop) begin
        r_fifo_empty <= (w_count_nxt == '0);
        r_fifo_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  tpu_state_e     r_state;
  tpu_state_e     w_state_nxt;
  logic           r_inject;
  logic [LAT-1:0] r_vpipe;
  logic           w_drain_empty;

  // Only the oldest vector (if any) may remain once this is true.
  assign w_drain_empty = (r_vpipe[LAT-2:0] == '0) && !r_inject;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.start)          w_state_nxt = ST_LOAD;
      ST_LOAD:   if (bus.we_rl)          w_state_nxt = ST_READY;
      ST_READY:  if (bus.valid_address)  w_state_nxt = ST_STREAM;
      ST_STREAM: if (!bus.valid_address) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drain_empty)      w_state_nxt = ST_DONE;
      ST_DONE:                           w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_inject <= 1'b0;
      r_vpipe  <= '0;
    end else begin
      r_inject <= w_sram_rd && ((r_state == ST_READY) || (r_state == ST_STREAM));
      r_vpipe  <= {r_vpipe[LAT-2:0], r_inject};
    end
  end

  // ------------------------------------------------------ systolic array
  logic [WEIGHT_BW-1:0]             w_a_h  [NUM_PE_ROWS][MATRIX_SIZE+1];
  logic [ACC_BW-1:0]                w_ps_v [NUM_PE_ROWS+1][MATRIX_SIZE];
  logic [ACC_BW-1:0]                w_col  [MATRIX_SIZE];
  logic [NUM_PE_ROWS*WEIGHT_BW-1:0] w_unused_a;

  generate
    for (genvar r = 0; r < NUM_PE_ROWS; r++) begin : g_skew
      logic [WEIGHT_BW-1:0] w_lane;
      assign w_lane = r_inject ? r_sram_dout[act_lsb(r, WEIGHT_BW) +: WEIGHT_BW] : '0;
      if (r == 0) begin : g_direct
        assign w_a_h[r][0] = w_lane;
      end else begin : g_delay
        logic [WEIGHT_BW-1:0] r_sh [r];
        always_ff @(posedge clk) begin
          if (rstn) begin
            for (int i = 0; i < r; i++) r_sh[i] <= '0;
          end else begin
            r_sh[0] <= w_lane;
            for (int i = 1; i < r; i++) r_sh[i] <= r_sh[i-1];
          end
        end
        assign w_a_h[r][0] = r_sh[r-1];
      end
      assign w_unused_a[r*WEIGHT_BW +: WEIGHT_BW] = w_a_h[r][MATRIX_SIZE];
    end

    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_top
      assign w_ps_v[0][c] = '0;
    end

    for (genvar r = 0; r < NUM_PE_ROWS; r++) begin : g_row
      for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
        tpu_pe #(
          .WEIGHT_BW (WEIGHT_BW),
          .ACC_BW    (ACC_BW)
        ) u_pe (
          .clk    (clk),
          .rstn   (rstn),
          .i_we   (bus.we_rl),
          .i_w    (r_fifo_dout[weight_lsb(r, c, MATRIX_SIZE, WEIGHT_BW) +: WEIGHT_BW]),
          .i_a    (w_a_h[r][c]),
          .i_psum (w_ps_v[r][c]),
          .o_a    (w_a_h[r][c+1]),
          .o_psum (w_ps_v[r+1][c])
        );
      end
    end

    // Column c leaves the array c cycles after column 0; pad it to line up.
    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_deskew
      localparam int DLY = MATRIX_SIZE - c;
      logic [ACC_BW-1:0] r_dq [DLY];
      always_ff @(posedge clk) begin
        if (rstn) begin
          for (int i = 0; i < DLY; i++) r_dq[i] <= '0;
        end else begin
          r_dq[0] <= w_ps_v[NUM_PE_ROWS][c];
          for (int i = 1; i < DLY; i++) r_dq[i] <= r_dq[i-1];
        end
      end
      assign w_col[c] = r_dq[DLY-1];
    end
  endgenerate

  // --------------------------------------------------------- output stage
  logic [MATRIX_SIZE*ACC_BW-1:0] w_psum_nxt;
  logic [MATRIX_SIZE*ACC_BW-1:0] r_psum_out;

  always_comb begin
    w_psum_nxt = '0;
    for (int c = 0; c < MATRIX_SIZE; c++) begin
`ifdef TPU_RELU_EN
      w_psum_nxt[c*ACC_BW +: ACC_BW] = w_col[c][ACC_BW-1] ? '0 : w_col[c];
`else
      w_psum_nxt[c*ACC_BW +: ACC_BW] = w_col[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_psum_out <= '0;
    end else begin
      r_psum_out <= w_psum_nxt;
    end
  end

  assign bus.sram_data_out = r_sram_dout;
  assign bus.fifo_data_out = r_fifo_dout;
  assign bus.fifo_empty    = r_fifo_empty;
  assign bus.fifo_full     = r_fifo_full;
  assign bus.psum_out      = r_psum_out;
  assign bus.psum_valid    = r_vpipe[LAT-1];
  assign bus.end_          = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_tpu_top.sv
// ============================================================================
// tb_tpu_top : self-checking bench for tpu_top against a matrix-vector model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tpu_top;

  localparam int AW  = 10;
  localparam int WS  = 64;
  localparam int WBW = 8;
  localparam int NR  = 8;
  localparam int MS  = 8;
  localparam int FD  = 4;
  localparam int ACC = 2 * WBW + $clog2(NR);
  localparam int DW  = WBW * NR * MS;
  localparam int LAT = NR + MS + 1;
  localparam int PW  = MS * ACC;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tpu_if #(
    .ADDRESSSIZE (AW), .WORDSIZE (WS), .WEIGHT_BW (WBW),
    .NUM_PE_ROWS (NR), .MATRIX_SIZE (MS)
  ) bus ();

  tpu_top #(
    .ADDRESSSIZE (AW), .WORDSIZE (WS), .WEIGHT_BW (WBW),
    .NUM_PE_ROWS (NR), .MATRIX_SIZE (MS), .FIFO_DEPTH (FD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [WS-1:0] words [16];
  logic [DW-1:0] mats  [5];
  logic [WS-1:0] job_words [3];
  int            wm [NR][MS];
  logic [PW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " end_"},          bus.end_,          '0);
    check({tag, " psum_valid"},    bus.psum_valid,    '0);
    check({tag, " psum_out"},      bus.psum_out,      '0);
    check({tag, " sram_data_out"}, bus.sram_data_out, '0);
    check({tag, " fifo_data_out"}, bus.fifo_data_out, '0);
    check({tag, " fifo_empty"},    bus.fifo_empty,    '0);
    check({tag, " fifo_full"},     bus.fifo_full,     '0);
  endtask

  function automatic logic [DW-1:0] pack_w();
    logic [DW-1:0] m;
    int            t;
    m = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < MS; c++) begin
        t = wm[r][c];
        m[(r*MS+c)*WBW +: WBW] = t[WBW-1:0];
      end
    return m;
  endfunction

  // Column sums y[c] = sum_r a[r]*W[r][c] in plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [WS-1:0] word);
    logic [PW-1:0]  res;
    logic [WBW-1:0] av;
    int             sum;
    res = '0;
    for (int c = 0; c < MS; c++) begin
      sum = 0;
      for (int r = 0; r < NR; r++) begin
        av  = word[r*WBW +: WBW];
        sum = sum + int'($signed(av)) * wm[r][c];
      end
`ifdef TPU_RELU_EN
      if (sum < 0) sum = 0;
`endif
      res[c*ACC +: ACC] = sum[ACC-1:0];
    end
    return res;
  endfunction

  task automatic rand_weights();
    logic [WBW-1:0] b;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < MS; c++) begin
        b = WBW'($urandom);
        wm[r][c] = int'($signed(b));
      end
  endtask

  task automatic idle_inputs();
    bus.start             = 1'b0;
    bus.sram_write_enable = 1'b0;
    bus.sram_address      = '0;
    bus.sram_data_in      = '0;
    bus.fifo_write_enable = 1'b0;
    bus.fifo_read_enable  = 1'b0;
    bus.fifo_data_in      = '0;
    bus.we_rl             = 1'b0;
    bus.valid_address     = 1'b0;
  endtask

  // Write job words to SRAM, push/pop/latch weights and start the job.
  task automatic prepare_job(input int n);
    for (int k = 0; k < n; k++) begin
      bus.sram_write_enable = 1'b1;
      bus.sram_address      = AW'(k);
      bus.sram_data_in      = job_words[k];
      tick();
    end
    bus.sram_write_enable = 1'b0;
    bus.fifo_write_enable = 1'b1;
    bus.fifo_data_in      = pack_w();
    tick();
    bus.fifo_write_enable = 1'b0;
    bus.start             = 1'b1;
    tick();
    bus.start             = 1'b0;
    bus.fifo_read_enable  = 1'b1;
    tick();
    bus.fifo_read_enable  = 1'b0;
    bus.we_rl             = 1'b1;
    tick();
    bus.we_rl             = 1'b0;
  endtask

  task automatic run_job(input int n, input string tag);
    int t0;
    int nv;
    bit done;
    t0 = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model(job_words[k]));
    prepare_job(n);
    for (int k = 0; k < n; k++) begin
      bus.valid_address = 1'b1;
      bus.sram_address  = AW'(k);
      tick();
      if (k == 0) t0 = cyc;
    end
    bus.valid_address = 1'b0;
    nv   = 0;
    done = 1'b0;
    for (int i = 0; i < LAT + 10 && !done; i++) begin
      tick();
      if (bus.psum_valid) begin
        if (nv == 0) check({tag, " latency"}, cyc - t0, LAT);
        if (exp_q.size() > 0) check({tag, " psum_out"}, bus.psum_out, exp_q.pop_front());
        else check({tag, " extra psum_valid"}, bus.psum_valid, '0);
        nv++;
      end else if (nv > 0) begin
        check({tag, " valid count"}, nv, n);
        check({tag, " end_ after last valid"}, bus.end_, 1'b1);
        done = 1'b1;
      end
    end
    check({tag, " drained in time"}, done, 1'b1);
    tick();
    check({tag, " end_ single pulse"}, bus.end_, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    idle_inputs();
    rstn = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    check_all_zero("reset");

    // SRAM write then read-back, one-cycle latency
    for (int i = 0; i < 15; i++) begin
      words[i]              = {$urandom, $urandom};
      bus.sram_write_enable = 1'b1;
      bus.sram_address      = AW'(i);
      bus.sram_data_in      = words[i];
      tick();
    end
    bus.sram_write_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.valid_address = 1'b1;
      bus.sram_address  = AW'(i);
      tick();
      if (i < 15) check($sformatf("sram rd %0d", i), bus.sram_data_out, words[i]);
    end
    bus.valid_address = 1'b0;
    check("no job from idle reads", bus.psum_valid, 1'b0);

    // FIFO fill, overflow push, drain, underflow pop
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < DW / 32; j++) mats[i][j*32 +: 32] = $urandom;
    for (int i = 0; i < 5; i++) begin
      bus.fifo_write_enable = 1'b1;
      bus.fifo_data_in      = mats[i];
      tick();
      if (i == 3) begin
        check("fifo full after 4", bus.fifo_full, 1'b1);
        check("fifo not empty after 4", bus.fifo_empty, 1'b0);
      end
    end
    bus.fifo_write_enable = 1'b0;
    check("fifo full after 5th push", bus.fifo_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.fifo_read_enable = 1'b1;
      tick();
      check($sformatf("fifo pop %0d", i), bus.fifo_data_out, mats[i]);
    end
    check("fifo empty after 4 pops", bus.fifo_empty, 1'b1);
    check("fifo not full after 4 pops", bus.fifo_full, 1'b0);
    tick();
    bus.fifo_read_enable = 1'b0;
    check("fifo pop when empty holds", bus.fifo_data_out, mats[3]);

    // Identity weights
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < MS; c++) wm[r][c] = (r == c) ? 1 : 0;
    job_words[0] = 64'h0807060504030201;
    run_job(1, "identity");

    // Most-negative-product style: all weights -1, activations 127
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < MS; c++) wm[r][c] = -1;
    job_words[0] = 64'h7F7F7F7F7F7F7F7F;
    run_job(1, "minus_one");

    // Three back-to-back random vectors
    rand_weights();
    for (int k = 0; k < 3; k++) job_words[k] = {$urandom, $urandom};
    run_job(3, "random3");

    // Reset while streaming
    rand_weights();
    for (int k = 0; k < 3; k++) job_words[k] = {$urandom, $urandom};
    prepare_job(3);
    bus.valid_address = 1'b1;
    bus.sram_address  = AW'(0);
    tick();
    bus.sram_address  = AW'(1);
    tick();
    bus.sram_address  = AW'(2);
    rstn              = 1'b1;
    tick();
    rstn              = 1'b0;
    bus.valid_address = 1'b0;
    check_all_zero("mid-stream reset");
    seen = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      tick();
      if (bus.end_ || bus.psum_valid) seen = 1'b1;
    end
    check("no end_/psum_valid after reset", seen, 1'b0);

    // Recovery job after reset
    rand_weights();
    for (int k = 0; k < 2; k++) job_words[k] = {$urandom, $urandom};
    run_job(2, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tpu_top.md
# tpu_top

Top level of the basic systolic-array TPU. Integrates a single-port activation SRAM, a weight FIFO holding whole 8x8 weight matrices, and a weight-stationary systolic array of NUM_PE_ROWS x MATRIX_SIZE processing elements (PEs). Weights are popped from the FIFO and latched into the array. SRAM words are then streamed through the array, which produces one column-sum vector per streamed word; `end_` pulses when the stream has drained.

## Interface
- ADDRESSSIZE, 10: SRAM address width; depth is 2^ADDRESSSIZE words.
- WORDSIZE, 64: SRAM word width; one word is NUM_PE_ROWS activations of WEIGHT_BW bits.
- WEIGHT_BW, 8: activation and weight width, signed two's complement.
- NUM_PE_ROWS, 8: number of array rows.
- MATRIX_SIZE, 8: number of array columns.
- FIFO_DEPTH, 4: number of weight-FIFO entries.
- clk  in  1  sole clock; all logic on the rising edge.
- rstn  in  1  reset; synchronous, active-high (1 resets on the clock edge).
- start  in  1  one-cycle pulse that begins a weight-load/compute job.
- end_  out  1  one-cycle done pulse.
- sram_write_enable  in  1  write `sram_data_in` to `sram_address`.
- sram_address  in  ADDRESSSIZE  shared read/write address.
- sram_data_in  in  WORDSIZE  write data.
- sram_data_out  out  WORDSIZE  registered read data.
- fifo_write_enable  in  1  push `fifo_data_in`.
- fifo_read_enable  in  1  pop the FIFO head.
- fifo_data_in  in  DW  one weight matrix, where DW = WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE (512).
- fifo_data_out  out  DW  registered popped entry.
- fifo_empty, fifo_full  out  1  FIFO status.
- we_rl  in  1  latch `fifo_data_out` into the PE weight registers.
- valid_address  in  1  read SRAM at `sram_address` and stream the word into the array.
- psum_out  out  MATRIX_SIZE*ACC_BW  column sums; column c sits at bits [c*ACC_BW +: ACC_BW].
- psum_valid  out  1  `psum_out` is valid.

## Operation
- Reset values: every output is 0; FIFO pointers and count are cleared; the FSM is in IDLE; PE weights and pipelines are cleared. SRAM array contents are not reset.
- Arithmetic: ACC_BW = 2*WEIGHT_BW + clog2(NUM_PE_ROWS), which is 19 for defaults. All arithmetic is signed and non-saturating.
- SRAM write: when `sram_write_enable`=1, mem[sram_address] <= sram_data_in.
- SRAM read: when `valid_address`=1 and `sram_write_enable`=0, sram_data_out <= mem[sram_address]. Otherwise `sram_data_out` holds.
- If `sram_write_enable` and `valid_address` are both high, the write wins and no read is issued.
- FIFO: circular buffer with a registered pop; on a pop, fifo_data_out <= head.
  - A push while full is ignored.
  - A pop while empty is ignored and `fifo_data_out` holds.
  - Simultaneous push and pop when neither flag blocks: both happen and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Weight mapping: matrix element W[r][c] is fifo_data_out[(r*MATRIX_SIZE+c)*WEIGHT_BW +: WEIGHT_BW]. On `we_rl`, PE(r,c) latches W[r][c].
- Activation mapping: activation lane r is sram_data_out[r*WEIGHT_BW +: WEIGHT_BW].
- Dataflow:
  - Lane r is skewed by r cycles, then flows rightward along row r.
  - Partial sums flow down each column.
  - Column outputs are deskewed so that all columns of one vector appear in the same cycle.
  - Result: psum_out[c] = Σ_r a[r]*W[r][c].
- FSM states: IDLE, LOAD, READY, STREAM, DRAIN, DONE.
  - IDLE goes to LOAD on `start`.
  - LOAD goes to READY on `we_rl`.
  - READY goes to STREAM on `valid_address`.
  - STREAM goes to DRAIN when `valid_address` falls.
  - DRAIN goes to DONE when the last `psum_valid` is emitted.
  - DONE asserts `end_` for one cycle and returns to IDLE.
- `start` outside IDLE is ignored.
- `valid_address` outside READY/STREAM still reads the SRAM but injects nothing into the array.
- A `we_rl` outside LOAD still reloads the weights.
- Reset in any state returns to IDLE and flushes all pipelines.

## Timing
- Pop to data: a pop at edge t puts data on `fifo_data_out` at t+1; `we_rl` at t+1 latches it.
- SRAM read latency is 1 cycle.
- Array latency is LAT = NUM_PE_ROWS + MATRIX_SIZE + 1, which is 17 for defaults.
  - Latency is measured from the cycle `valid_address` is sampled to `psum_valid`: the SRAM read takes 1 cycle and the array path from `sram_data_out` to `psum_valid` takes LAT cycles.
  - The array accepts one vector per cycle with no bubbles.
- `end_` is asserted in the cycle after the last `psum_valid`.
- FIFO flags are registered and update in the same edge as the push or pop.

## Configuration
- `TPU_RELU_EN` defined: each `psum_out` column is clamped to 0 when negative; the clamp adds no latency.
- `TPU_RELU_EN` undefined: raw signed sums are output.

## Structure
- Package `tpu_pkg` holds the FSM state enum, the ACC_BW function/constant, and the field index helpers for weights and activations.
- One sub-module, `tpu_pe`: weight register, multiply-accumulate, registered activation pass-right and registered psum pass-down.
- The SRAM, FIFO, skew/deskew logic and FSM are inline in `tpu_top`.

## Test plan
- Write 15 words to SRAM at addresses 0..14, then read 0..15 with `valid_address`: `sram_data_out` equals the written word 1 cycle later; address 15 returns unwritten memory and no X is propagated into the control logic.
- Push 4 matrices: `fifo_full`=1 after the 4th; a 5th push is ignored. Pop 4: data returns in FIFO order and `fifo_empty`=1; a further pop leaves `fifo_data_out` unchanged.
- Identity weights, stream the word 0x0807060504030201: after LAT+1 cycles `psum_out` columns equal 1..8; `end_` pulses one cycle after `psum_valid` drops.
- All weights -1 and all activations 127: every column reads -1016. With `TPU_RELU_EN` defined, every column reads 0.
- Stream 3 back-to-back words: `psum_valid` is high for exactly 3 consecutive cycles and the results are in input order.
- Assert `rstn` mid-STREAM: the next cycle has every output at 0, and no `end_` follows.
